// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF formatter receive path: length codes, receiver FSM states and
// the layout of one buffered word.
package mcdf_pkg;

   localparam logic [5:0] LEN4  = 6'd4;
   localparam logic [5:0] LEN8  = 6'd8;
   localparam logic [5:0] LEN16 = 6'd16;
   localparam logic [5:0] LEN32 = 6'd32;

   localparam int unsigned ENTRY_W = 36;

   typedef enum logic [1:0] {IDLE, WAIT_SOP, RECV, DRAIN} rx_state_e;

   typedef struct packed {
      logic [1:0]  child;
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } rx_entry_t;

   // Unknown length codes are treated as the largest packet so the space check stays safe.
   function automatic logic [5:0] len_words(input logic [5:0] len);
      logic [5:0] words;
      case (len)
         LEN4, LEN8, LEN16: words = len;
         default:           words = LEN32;
      endcase
      return words;
   endfunction

endpackage

// File: rtl/fmt_receiver_if.sv
// Formatter request/grant/word stream plus the buffered valid/ready output port.
interface fmt_receiver_if;

   logic        fmt_req;
   logic [1:0]  fmt_child;
   logic [5:0]  fmt_length;
   logic        fmt_grant;
   logic        fmt_start;
   logic [31:0] fmt_data;
   logic        fmt_end;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_data;
   logic [1:0]  o_child;
   logic        o_sop;
   logic        o_eop;

   modport master (
      output fmt_req, fmt_child, fmt_length, fmt_start, fmt_data, fmt_end, o_ready,
      input  fmt_grant, o_valid, o_data, o_child, o_sop, o_eop
   );

   modport slave (
      input  fmt_req, fmt_child, fmt_length, fmt_start, fmt_data, fmt_end, o_ready,
      output fmt_grant, o_valid, o_data, o_child, o_sop, o_eop
   );

endinterface

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO; the head entry is presented on rdata_o and reads as zero when empty.
module rx_fifo #(
   parameter  int unsigned DEPTH = 64,
   parameter  int unsigned WIDTH = 36,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW + 1)'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/fmt_receiver.sv
// Receiving end of the MCDF formatter link: grants a packet only when it fits in the buffer,
// checks its word count against the granted length and streams the words out.
module fmt_receiver
   import mcdf_pkg::*;
#(
   parameter  int unsigned DEPTH    = 64,
   parameter  int unsigned START_TO = 4,
   localparam int unsigned CW       = $clog2(DEPTH) + 1,
   localparam int unsigned TW       = $clog2(START_TO + 1)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             rx_en_i,
   fmt_receiver_if.slave    rx_if,
   output logic [CW-1:0]    free_o,
   output logic             len_err_o,
   output logic             to_err_o
);

   rx_state_e   state_q, state_d;
   logic [1:0]  cur_child_q, cur_child_d;
   logic [5:0]  cur_len_q, cur_len_d;
   logic [5:0]  wcnt_q, wcnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic        grant_q, grant_d;
   logic        len_err_q, len_err_d;
   logic        to_err_q, to_err_d;

   logic        push_req;
   logic        push;
   logic        pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [5:0]  wcnt_inc;
   rx_entry_t   wentry;
   rx_entry_t   rentry;

   assign wcnt_inc = wcnt_q + 6'd1;
   assign free_o   = CW'(DEPTH) - fifo_count;

   always_comb begin
      state_d     = state_q;
      cur_child_d = cur_child_q;
      cur_len_d   = cur_len_q;
      wcnt_d      = wcnt_q;
      to_cnt_d    = to_cnt_q;
      grant_d     = 1'b0;
      len_err_d   = 1'b0;
      to_err_d    = 1'b0;
      push_req    = 1'b0;
      wentry      = '{child: cur_child_q, sop: 1'b0, eop: 1'b0, data: rx_if.fmt_data};

      unique case (state_q)
         IDLE: begin
            if (rx_if.fmt_req && rx_en_i && (free_o >= CW'(len_words(rx_if.fmt_length)))) begin
               grant_d     = 1'b1;
               cur_child_d = rx_if.fmt_child;
               cur_len_d   = len_words(rx_if.fmt_length);
               to_cnt_d    = '0;
               state_d     = WAIT_SOP;
            end
         end
         WAIT_SOP: begin
            if (rx_if.fmt_start) begin
               push_req   = 1'b1;
               wentry.sop = 1'b1;
               wentry.eop = rx_if.fmt_end;
               wcnt_d     = 6'd1;
               if (rx_if.fmt_end) begin
                  // A one-word packet is always shorter than any legal length.
                  len_err_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  state_d = RECV;
               end
            end else if (to_cnt_q == TW'(START_TO - 1)) begin
               to_err_d = 1'b1;
               state_d  = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         RECV: begin
            push_req   = 1'b1;
            wcnt_d     = wcnt_inc;
            wentry.eop = rx_if.fmt_end || (wcnt_inc == cur_len_q);
            if (rx_if.fmt_end) begin
               len_err_d = (wcnt_inc != cur_len_q);
               state_d   = IDLE;
            end else if (wcnt_inc == cur_len_q) begin
               // Over-long packet: close it at the granted length and drop the tail.
               len_err_d = 1'b1;
               state_d   = DRAIN;
            end
         end
         DRAIN: begin
            if (rx_if.fmt_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         cur_child_q <= '0;
         cur_len_q   <= '0;
         wcnt_q      <= '0;
         to_cnt_q    <= '0;
         grant_q     <= 1'b0;
         len_err_q   <= 1'b0;
         to_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_child_q <= cur_child_d;
         cur_len_q   <= cur_len_d;
         wcnt_q      <= wcnt_d;
         to_cnt_q    <= to_cnt_d;
         grant_q     <= grant_d;
         len_err_q   <= len_err_d;
         to_err_q    <= to_err_d;
      end
   end

   assign push = push_req && !fifo_full;
   assign pop  = !fifo_empty && rx_if.o_ready;

   rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_rx_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (push),
      .wdata_i (wentry),
      .pop_i   (pop),
      .rdata_o (rentry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rx_if.fmt_grant = grant_q;
   assign rx_if.o_valid   = !fifo_empty;
   assign rx_if.o_data    = rentry.data;
   assign rx_if.o_child   = rentry.child;
   assign rx_if.o_sop     = rentry.sop;
   assign rx_if.o_eop     = rentry.eop;
   assign len_err_o       = len_err_q;
   assign to_err_o        = to_err_q;

endmodule

// File: tb/tb_fmt_receiver.sv
// Bench for fmt_receiver: a packet-level formatter driver feeds an expected-word queue that a
// per-cycle monitor compares against the output port, flags and free count.
module tb_fmt_receiver;
   import mcdf_pkg::*;

   localparam int unsigned DEPTH    = 64;
   localparam int unsigned START_TO = 4;

   typedef struct {
      logic [1:0]  child;
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } word_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx_en = 1'b0;
   logic [6:0] free;
   logic       len_err;
   logic       to_err;

   fmt_receiver_if bus ();

   fmt_receiver #(
      .DEPTH    (DEPTH),
      .START_TO (START_TO)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .rx_en_i   (rx_en),
      .rx_if     (bus),
      .free_o    (free),
      .len_err_o (len_err),
      .to_err_o  (to_err)
   );

   always #5 clk = ~clk;

   word_t exp_q[$];
   word_t out_log[$];
   int    checks = 0;
   int    failures = 0;
   int    len_err_seen = 0;
   int    to_err_seen = 0;
   logic  exp_grant = 1'b0;
   logic  exp_len_err = 1'b0;
   logic  exp_to_err = 1'b0;
   bit    check_en = 1'b0;
   bit    rand_ready = 1'b0;
   logic  ready_fixed = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      bus.o_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
   end

   // Per-cycle monitor; the model queue pops whenever downstream is ready and it holds a word.
   always @(negedge clk) begin
      word_t w;
      if (rstn && check_en) begin
         chk("o_valid", 32'(bus.o_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("o_data", bus.o_data, exp_q[0].data);
            chk("o_child", 32'(bus.o_child), 32'(exp_q[0].child));
            chk("o_sop", 32'(bus.o_sop), 32'(exp_q[0].sop));
            chk("o_eop", 32'(bus.o_eop), 32'(exp_q[0].eop));
         end
         chk("free_o", 32'(free), 32'(DEPTH - exp_q.size()));
         chk("grant", 32'(bus.fmt_grant), 32'(exp_grant));
         chk("len_err", 32'(len_err), 32'(exp_len_err));
         chk("to_err", 32'(to_err), 32'(exp_to_err));
         if (len_err === 1'b1) len_err_seen++;
         if (to_err === 1'b1) to_err_seen++;
         if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
            w = '{bus.o_child, bus.o_sop, bus.o_eop, bus.o_data};
            out_log.push_back(w);
         end
         if (exp_q.size() != 0 && bus.o_ready === 1'b1) void'(exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_grant   = 1'b0;
      exp_len_err = 1'b0;
      exp_to_err  = 1'b0;
   endtask

   // Returns in the grant cycle; a grant is due whenever enabled and the packet fits.
   task automatic request(input logic [5:0] len, input logic [1:0] child, output bit granted);
      int bound = 3000;
      bit ok;
      granted = 1'b0;
      bus.fmt_req    = 1'b1;
      bus.fmt_length = len;
      bus.fmt_child  = child;
      while (!granted && bound > 0) begin
         ok = (rx_en == 1'b1) && (int'(DEPTH) - exp_q.size() >= int'(len));
         tick();
         bound--;
         if (ok) begin
            granted     = 1'b1;
            exp_grant   = 1'b1;
            bus.fmt_req = 1'b0;
         end
      end
      if (!granted) begin
         checks++;
         failures++;
         $display("FAIL grant_wait: got no grant expected grant for len %0d", len);
         bus.fmt_req = 1'b0;
      end
   endtask

   // Sends n words starting the cycle after the grant; only the first len words are kept.
   task automatic send(input logic [5:0] len, input logic [1:0] child, input int n,
                       input logic [31:0] base);
      int kept;
      word_t w;
      kept = (n < int'(len)) ? n : int'(len);
      tick();
      for (int k = 0; k < n; k++) begin
         bus.fmt_start = (k == 0);
         bus.fmt_end   = (k == n - 1);
         bus.fmt_data  = base + 32'(k);
         tick();
         bus.fmt_start = 1'b0;
         bus.fmt_end   = 1'b0;
         if (k < int'(len)) begin
            w = '{child, (k == 0), (k == n - 1) || (k == int'(len) - 1), base + 32'(k)};
            exp_q.push_back(w);
         end
         if (n != int'(len) && k == kept - 1) exp_len_err = 1'b1;
      end
   endtask

   task automatic no_start();
      for (int i = 1; i <= int'(START_TO); i++) begin
         tick();
         if (i == int'(START_TO)) exp_to_err = 1'b1;
      end
   endtask

   task automatic drain();
      int b = 600;
      while (exp_q.size() != 0 && b > 0) begin
         tick();
         b--;
      end
      tick();
      tick();
      if (b == 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d words left expected 0", exp_q.size());
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_grant"}, 32'(bus.fmt_grant), 32'd0);
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
      chk({tag, "_data"}, bus.o_data, 32'd0);
      chk({tag, "_child"}, 32'(bus.o_child), 32'd0);
      chk({tag, "_sop"}, 32'(bus.o_sop), 32'd0);
      chk({tag, "_eop"}, 32'(bus.o_eop), 32'd0);
      chk({tag, "_free"}, 32'(free), 32'd64);
      chk({tag, "_len_err"}, 32'(len_err), 32'd0);
      chk({tag, "_to_err"}, 32'(to_err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bit g;
      logic [5:0] lens [4];
      logic [5:0] len;
      int mode;
      int n;
      word_t w;
      lens[0] = LEN4; lens[1] = LEN8; lens[2] = LEN16; lens[3] = LEN32;
      bus.fmt_req = 1'b0; bus.fmt_child = '0; bus.fmt_length = LEN4;
      bus.fmt_start = 1'b0; bus.fmt_end = 1'b0; bus.fmt_data = '0;

      #12;
      chk_reset("rst");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      rx_en = 1'b1;
      check_en = 1'b1;

      // Nominal packet
      out_log.delete(); len_err_seen = 0;
      request(LEN8, 2'd2, g);
      if (g) send(LEN8, 2'd2, 8, 32'h100);
      drain();
      chk("nom_count", 32'(out_log.size()), 32'd8);
      chk("nom_first_data", out_log[0].data, 32'h100);
      chk("nom_first_sop", 32'(out_log[0].sop), 32'd1);
      chk("nom_first_child", 32'(out_log[0].child), 32'd2);
      chk("nom_last_data", out_log[7].data, 32'h107);
      chk("nom_last_eop", 32'(out_log[7].eop), 32'd1);
      chk("nom_free", 32'(free), 32'd64);
      chk("nom_no_err", 32'(len_err_seen), 32'd0);

      // Short packet
      out_log.delete(); len_err_seen = 0;
      request(LEN16, 2'd1, g);
      if (g) send(LEN16, 2'd1, 10, 32'h200);
      drain();
      chk("short_count", 32'(out_log.size()), 32'd10);
      chk("short_last_data", out_log[9].data, 32'h209);
      chk("short_last_eop", 32'(out_log[9].eop), 32'd1);
      chk("short_err_pulses", 32'(len_err_seen), 32'd1);

      // Long packet
      out_log.delete(); len_err_seen = 0;
      request(LEN4, 2'd3, g);
      if (g) send(LEN4, 2'd3, 6, 32'h300);
      drain();
      chk("long_count", 32'(out_log.size()), 32'd4);
      chk("long_last_data", out_log[3].data, 32'h303);
      chk("long_last_eop", 32'(out_log[3].eop), 32'd1);
      chk("long_err_pulses", 32'(len_err_seen), 32'd1);

      // Start timeout, then a clean packet
      out_log.delete(); to_err_seen = 0;
      request(LEN8, 2'd0, g);
      if (g) no_start();
      request(LEN4, 2'd0, g);
      if (g) send(LEN4, 2'd0, 4, 32'h400);
      drain();
      chk("to_pulses", 32'(to_err_seen), 32'd1);
      chk("to_next_count", 32'(out_log.size()), 32'd4);

      // Grants withheld while disabled
      rx_en = 1'b0;
      bus.fmt_req = 1'b1;
      bus.fmt_length = LEN4;
      repeat (6) tick();
      rx_en = 1'b1;

      // Backpressure: two full packets, third waits for space
      out_log.delete();
      ready_fixed = 1'b0;
      request(LEN32, 2'd1, g);
      if (g) send(LEN32, 2'd1, 32, 32'h1000);
      request(LEN32, 2'd2, g);
      if (g) send(LEN32, 2'd2, 32, 32'h2000);
      chk("bp_full", 32'(free), 32'd0);
      fork
         request(LEN4, 2'd3, g);
         begin
            repeat (20) @(posedge clk);
            #1;
            rand_ready = 1'b1;
         end
      join
      if (g) send(LEN4, 2'd3, 4, 32'h3000);
      rand_ready = 1'b0;
      ready_fixed = 1'b1;
      drain();
      chk("bp_count", 32'(out_log.size()), 32'd68);
      chk("bp_word32", out_log[32].data, 32'h2000);
      chk("bp_last", out_log[67].data, 32'h3003);

      // Reset in the middle of a packet
      request(LEN8, 2'd1, g);
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.fmt_start = (k == 0);
         bus.fmt_data  = 32'h500 + 32'(k);
         tick();
         bus.fmt_start = 1'b0;
         w = '{2'd1, (k == 0), 1'b0, 32'h500 + 32'(k)};
         exp_q.push_back(w);
      end
      rstn = 1'b0;
      exp_q.delete();
      #1;
      chk_reset("midrst");
      tick();
      tick();
      rstn = 1'b1;
      tick();
      out_log.delete();
      request(LEN8, 2'd2, g);
      if (g) send(LEN8, 2'd2, 8, 32'h600);
      drain();
      chk("post_rst_count", 32'(out_log.size()), 32'd8);
      chk("post_rst_first", out_log[0].data, 32'h600);

      // Randomised packets with random downstream stalls
      rand_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         len  = lens[$urandom_range(0, 3)];
         mode = $urandom_range(0, 9);
         request(len, 2'($urandom_range(0, 3)), g);
         if (g) begin
            if (mode == 0) begin
               no_start();
            end else begin
               if (mode == 1)      n = $urandom_range(1, int'(len) - 1);
               else if (mode == 2) n = int'(len) + $urandom_range(1, 3);
               else                n = int'(len);
               send(len, bus.fmt_child, n, $urandom);
            end
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_ready = 1'b0;
      ready_fixed = 1'b1;
      drain();
      chk("final_free", 32'(free), 32'd64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fmt_receiver.md
# fmt_receiver

Downstream end of the MCDF formatter interface. Grants packet requests from the formatter only when its internal buffer can hold the full advertised packet length. It then captures the start/data/end word stream, checks the word count against the length latched at grant, and presents buffered words on a valid/ready output port. Word-level tags (channel id, SOP, EOP) are carried to the output.

## Interface

Parameters:
- DEPTH, 64: buffer depth in 32-bit words; power of 2, at least 32 (the largest packet).
- START_TO, 4: maximum number of cycles from grant to fmt_start_i before a timeout.

Ports:
- clk_i, input, 1: clock.
- rstn_i, input, 1: reset; asynchronous, active-low.
- rx_en_i, input, 1: enables new grants. A packet already granted always completes.
- fmt_req_i, input, 1: formatter has a packet pending.
- fmt_child_i, input, 2: channel id of the pending packet.
- fmt_length_i, input, 6: packet length in words; legal values 4, 8, 16, 32.
- fmt_grant_o, output, 1: one-cycle grant pulse.
- fmt_start_i, input, 1: marks the first data word.
- fmt_data_i, input, 32: data word.
- fmt_end_i, input, 1: marks the last data word.
- o_valid_o, output, 1: output word valid.
- o_ready_i, input, 1: downstream ready.
- o_data_o, output, 32: output word.
- o_child_o, output, 2: channel id of the output word.
- o_sop_o, output, 1: output word is first of its packet.
- o_eop_o, output, 1: output word is last of its packet.
- free_o, output, log2(DEPTH)+1: free buffer entries.
- len_err_o, output, 1: one-cycle pulse on a length mismatch.
- to_err_o, output, 1: one-cycle pulse on a start timeout.

## Operation

- FSM states:
  - IDLE: when fmt_req_i && rx_en_i && (free_o >= fmt_length_i), register fmt_grant_o=1 and go to WAIT_SOP. In the same cycle, latch cur_child=fmt_child_i and cur_len=fmt_length_i.
  - WAIT_SOP: grant is low. On fmt_start_i, write word 0 with SOP=1, set wcnt=1, go to RECV. A word arriving with both fmt_start_i and fmt_end_i is a 1-word packet with EOP set and len_err (length < 4). If START_TO cycles pass without fmt_start_i, pulse to_err_o and return to IDLE.
  - RECV: write one word every cycle and increment wcnt.
    - On fmt_end_i: write with EOP=1 and go to IDLE. If wcnt+1 != cur_len, also pulse len_err_o.
    - If wcnt+1 == cur_len without fmt_end_i: write that word with EOP=1, pulse len_err_o, go to DRAIN.
  - DRAIN: discard words; on fmt_end_i go to IDLE.
- fmt_start_i outside WAIT_SOP: ignored, no write.
- Buffer entry is 36 bits: {child, sop, eop, data}. Words are written only in WAIT_SOP (on start) and RECV. Maximum write count per packet is cur_len, so the buffer cannot overflow.
- Grants are issued only from IDLE, so there is no outstanding reservation. free_o = DEPTH - count.
- Output is show-ahead: o_valid_o = !empty. A pop happens when o_valid_o && o_ready_i.
- Simultaneous push and pop: count is unchanged. Pop from empty and push to full cannot occur.
- wcnt is 6 bits, compared against cur_len. An unknown fmt_length_i is treated as 32 (the formatter never sends one).

## Timing

- Reset values: fmt_grant_o=0, o_valid_o=0, o_data_o=0, o_child_o=0, o_sop_o=0, o_eop_o=0, free_o=DEPTH, len_err_o=0, to_err_o=0. FSM is in IDLE, buffer is empty.
- Grant latency: the grant is high in the cycle after fmt_req_i is sampled with sufficient space. It is high for exactly 1 cycle.
- The formatter drives fmt_start_i with word 0 one cycle after the grant. Words then follow back-to-back until fmt_end_i.
- Write-to-output latency: a word written at edge N is visible on o_* after edge N (valid in cycle N+1).
- free_o is registered and updates one cycle after each push or pop.
- After fmt_end_i, the FSM is in IDLE in the next cycle and may grant immediately if fmt_req_i is high. The formatter's own end-delayed request gives at least a 1-cycle gap between packets.
- Error pulses are asserted the cycle after the offending word.
- Reset mid-packet: all state clears immediately. The partial packet is lost; there is no recovery signalling.

## Structure

- Shared package mcdf_pkg holds:
  - Length encodings: LEN4, LEN8, LEN16, LEN32.
  - FSM state enum: IDLE, WAIT_SOP, RECV, DRAIN.
  - Buffer entry width: 36.
- One sub-module, rx_fifo: synchronous show-ahead FIFO with parameters DEPTH and WIDTH=36, and outputs full, empty and count.
- The FSM, counters and error logic live in fmt_receiver.

## Test plan

- Nominal: child=2, len=8, 8 words 0x100..0x107, end on the last word -> grant 1 cycle; 8 words out in order, child=2, SOP on 0x100, EOP on 0x107; no errors; free_o returns to 64.
- Backpressure: o_ready_i=0, DEPTH=64; send two 32-word packets, then request a third with len=4 -> third grant withheld until ≥4 pops; no data loss.
- Short packet: len=16, fmt_end_i on word 10 -> 10 words out, EOP on word 10, len_err_o pulses once.
- Long packet: len=4, 6 words sent -> 4 words out, EOP on word 4, len_err_o pulses, words 5–6 dropped, FSM back in IDLE after end.
- Timeout: grant issued, no fmt_start_i for 4 cycles -> to_err_o pulses, FSM in IDLE, next request granted normally.
- Reset mid-packet: assert rstn_i low after 3 of 8 words -> all outputs at reset values, free_o=64, next packet received cleanly.
